// File: rtl/vedic_mul16_seq.sv
// vedic_mul16_seq -- sequential 16x16 unsigned multiplier.
// The product is built from four 8x8 partial products, one per cycle,
// and accumulated in a 32-bit register.
// Optional build macro: VEDIC_ZERO_SKIP_EN. When it is defined, a zero
// operand sends the FSM straight from IDLE to DONE. The result is the
// same in both builds; only the latency changes.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. Input side: in_valid/in_ready, where in_ready is high
// only in IDLE. Output side: out_valid/out_ready, where out_valid is high
// only in DONE. While out_ready is low, product and out_valid hold.
module vedic_mul16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PP0  = 3'd1,
        ST_PP1  = 3'd2,
        ST_PP2  = 3'd3,
        ST_PP3  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;

    logic [7:0]  pp_a;
    logic [7:0]  pp_b;
    logic [15:0] pp;
    logic [31:0] pp_ext;

    // State register. Reset is asynchronous, so an active reset aborts
    // any operation that is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latches and the accumulator. product is driven from acc_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= 16'd0;
            b_q   <= 16'd0;
            acc_q <= 32'd0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    // Select the byte pair for the current PP state, then place the
    // 8x8 product at its weight.
    always_comb begin
        pp_a   = 8'd0;
        pp_b   = 8'd0;
        pp_ext = 32'd0;
        case (state_q)
            ST_PP0:  begin pp_a = a_q[7:0];  pp_b = b_q[7:0];  end
            ST_PP1:  begin pp_a = a_q[15:8]; pp_b = b_q[7:0];  end
            ST_PP2:  begin pp_a = a_q[7:0];  pp_b = b_q[15:8]; end
            ST_PP3:  begin pp_a = a_q[15:8]; pp_b = b_q[15:8]; end
            default: begin pp_a = 8'd0;      pp_b = 8'd0;      end
        endcase
        pp = {8'd0, pp_a} * {8'd0, pp_b};
        case (state_q)
            ST_PP0:         pp_ext = {16'd0, pp};
            ST_PP1, ST_PP2: pp_ext = {8'd0, pp, 8'd0};
            ST_PP3:         pp_ext = {pp, 16'd0};
            default:        pp_ext = 32'd0;
        endcase
    end

    // Next-state and datapath update. The four PP steps are unconditional.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 32'd0;
                    state_d = ST_PP0;
`ifdef VEDIC_ZERO_SKIP_EN
                    if (a == 16'd0 || b == 16'd0) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_PP0: begin
                acc_d   = acc_q + pp_ext;
                state_d = ST_PP1;
            end
            ST_PP1: begin
                acc_d   = acc_q + pp_ext;
                state_d = ST_PP2;
            end
            ST_PP2: begin
                acc_d   = acc_q + pp_ext;
                state_d = ST_PP3;
            end
            ST_PP3: begin
                acc_d   = acc_q + pp_ext;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        out_valid = (state_q == ST_DONE);
        product   = acc_q;
        dbg_state = state_q;
    end

endmodule
